rr_mux_arbiter_4: RTL and testbench
===================================

Name: rr_mux_arbiter_4

Overview:
- Round-robin arbiter that shares one registered output channel between four requesters.
- Each requester presents a data word with a valid/ready handshake.
- The block picks one requester per cycle, steers its data through a 4:1 select and registers the result with the source index.
- Sits in front of any single-consumer datapath that several producers must share.

Parameters:
W, 4, data width of every requester port and of out_data.

Ports:
clk  input  1  clock; all state changes on posedge.
rst  input  1  synchronous, active-high reset.
req_valid  input  4  bit i set: requester i presents a word on d<i>.
d0  input  W  requester 0 data.
d1  input  W  requester 1 data.
d2  input  W  requester 2 data.
d3  input  W  requester 3 data.
req_ready  output  4  one-hot or zero; bit i set: d<i> is accepted this cycle.
out_valid  output  1  out_data/out_sel hold a word.
out_data  output  W  registered selected data.
out_sel  output  2  index of the requester that supplied out_data.
out_ready  input  1  consumer accepts the current output word this cycle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0. The values hold while rst=1, and req_ready=0 while rst=1.
- Slot free: can_load = !out_valid || out_ready, evaluated combinationally.
- Winner selection (combinational):
  - Search req_valid in order ptr, ptr+1, ptr+2, ptr+3, each index mod 4 (wrap 3 -> 0).
  - The first set bit is the winner win.
  - Nothing is granted if req_valid=0.
- Grant: req_ready[win]=1 iff can_load && req_valid!=0 && !rst. All other bits are 0. req_ready never depends on req_valid[j] for j != win.
- Transfer for requester i: happens on a cycle where req_valid[i] && req_ready[i].
- On a transfer at posedge:
  - out_valid<=1.
  - out_data<=d<win>.
  - out_sel<=win.
  - ptr<=(win+1) mod 4.
- If can_load and no request: out_valid<=0 when out_ready=1. out_data, out_sel and ptr hold.
- If !can_load (out_valid=1, out_ready=0):
  - All registers hold.
  - req_ready=0.
  - out_data and out_sel stay stable until accepted.
- Timing:
  - Latency: 1 cycle from accepted request to out_valid.
  - Throughput: 1 word/cycle when out_ready is held at 1.
  - Simultaneous consume and load: the old word leaves and the new word loads in the same cycle, with no bubble.
- Fairness: a requester holding req_valid=1 is granted within at most 4 transfers. Never starved.
- Requester contract: once req_valid[i]=1, the requester keeps it and d<i> stable until granted. The arbiter does not check this.
- ptr advances only on a transfer, never on idle or stall cycles.
- Reset mid-operation: any pending output word is discarded (out_valid=0) and ptr returns to 0 on the next edge.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, out_valid=0, out_data=0, out_sel=0. After release, the first grant goes to requester 0.
- Round-robin rotation:
  - Stimulus: req_valid=4'b1111 held, d0..d3=a,b,c,d, out_ready=1, for 8 cycles.
  - Required: out_sel sequence 0,1,2,3,0,1,2,3; out_data a,b,c,d,a,b,c,d.
  - Required: out_valid=1 from cycle 1 onward, with no gaps.
- Sparse request with pointer skip:
  - Stimulus: ptr=0, req_valid=4'b1010, d1=7, d3=3.
  - Required: first grant to 1 (out_data=7), next grant to 3 (out_data=3), then 1 again.
- Backpressure:
  - Stimulus: out_ready=0 after the first word (out_sel=2, out_data=c) for 3 cycles.
  - Required: req_ready=0, out_data/out_sel/out_valid stable, ptr unchanged.
  - Then out_ready=1 -> next word loads in the same cycle the held word leaves.
- Drain and idle:
  - Stimulus: req_valid=0, out_ready=1 while one word is pending.
  - Required: out_valid falls to 0 after one cycle, out_data holds its last value, ptr unchanged.
- Reset mid-stream: assert rst while out_valid=1 and ptr=2 -> next edge gives out_valid=0; after release with req_valid=4'b1111, the first grant goes to 0.

Source files
------------

// File: rtl/rr_mux_arbiter_4.sv
// Round-robin arbiter that steers one of four valid/ready requesters into a
// single registered output slot, tagging each word with its source index.
module rr_mux_arbiter_4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   req_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_sel,
    input  logic         out_ready
);

    logic [1:0]   ptr;
    logic [1:0]   win;
    logic [1:0]   idx;
    logic         can_load;
    logic         grant;
    logic [W-1:0] win_data;

    // Scanning from ptr+3 down to ptr leaves the earliest set bit in priority
    // order as the winner, so the search wraps naturally in 2-bit arithmetic.
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req_valid[idx]) begin
                win = idx;
            end
        end
    end

    always_comb begin
        can_load  = !out_valid || out_ready;
        grant     = can_load && (req_valid != 4'b0000) && !rst;
        req_ready = grant ? (4'b0001 << win) : 4'b0000;
    end

    always_comb begin
        case (win)
            2'd0:    win_data = d0;
            2'd1:    win_data = d1;
            2'd2:    win_data = d2;
            default: win_data = d3;
        endcase
    end

    // The pointer only moves past a requester that actually transferred,
    // which is what bounds every waiting requester to four transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
            ptr       <= 2'd0;
        end else if (grant) begin
            out_valid <= 1'b1;
            out_data  <= win_data;
            out_sel   <= win;
            ptr       <= win + 2'd1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter_4.sv
// Directed bench for rr_mux_arbiter_4: reset, rotation, sparse requests,
// backpressure, drain and mid-stream reset with hand-computed expectations.
module tb_rr_mux_arbiter_4;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_sel;
    logic         out_ready;

    int compared   = 0;
    int mismatched = 0;

    logic [W-1:0] word [4];

    rr_mux_arbiter_4 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic [3:0] rv, input logic ordy);
        rst       = rst_v;
        req_valid = rv;
        out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWord(input string tag, input logic v, input logic [1:0] sel,
                             input logic [W-1:0] data);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(v));
        checkOutput({tag, "_sel"},   32'(out_sel),   32'(sel));
        checkOutput({tag, "_data"},  32'(out_data),  32'(data));
    endtask

    initial begin
        word[0] = 4'hA;
        word[1] = 4'hB;
        word[2] = 4'hC;
        word[3] = 4'hD;
        d0 = word[0]; d1 = word[1]; d2 = word[2]; d3 = word[3];
        rst = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;

        // Reset held for two edges with every requester asking.
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("rst_ready", 32'(req_ready), 32'h0);
            checkWord("rst", 1'b0, 2'd0, 4'h0);
        end

        // Full-load rotation: one word per cycle, 0,1,2,3,0,1,2,3.
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("rot_first_grant", 32'(req_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkWord("rot", 1'b1, 2'(i % 4), word[i % 4]);
            checkOutput("rot_ready", 32'(req_ready), 32'(4'b0001 << ((i + 1) % 4)));
        end

        // Sparse requests 1 and 3 starting from ptr=0.
        d1 = 4'd7; d3 = 4'd3;
        applyStimulus(1'b0, 4'b1010, 1'b1);
        checkOutput("sparse_ready0", 32'(req_ready), 32'h2);
        tick();
        checkWord("sparse0", 1'b1, 2'd1, 4'd7);
        checkOutput("sparse_ready1", 32'(req_ready), 32'h8);
        tick();
        checkWord("sparse1", 1'b1, 2'd3, 4'd3);
        checkOutput("sparse_ready2", 32'(req_ready), 32'h2);
        tick();
        checkWord("sparse2", 1'b1, 2'd1, 4'd7);

        // Backpressure on a held word from requester 2.
        d1 = word[1]; d3 = word[3];
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("bp_grant", 32'(req_ready), 32'h4);
        tick();
        checkWord("bp_first", 1'b1, 2'd2, word[2]);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_ready", 32'(req_ready), 32'h0);
            tick();
            checkWord("bp_hold", 1'b1, 2'd2, word[2]);
            checkOutput("bp_ptr", 32'(dut.ptr), 32'd3);
        end
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("bp_release_ready", 32'(req_ready), 32'h8);
        tick();
        checkWord("bp_release", 1'b1, 2'd3, word[3]);

        // Drain: no requests, pending word consumed, data and pointer hold.
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("drain_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkWord("drain", 1'b0, 2'd3, word[3]);
            checkOutput("drain_ptr", 32'(dut.ptr), 32'd0);
        end

        // Mid-stream reset with a held word and ptr=2.
        applyStimulus(1'b0, 4'b0010, 1'b1);
        tick();
        checkWord("pre_rst", 1'b1, 2'd1, word[1]);
        checkOutput("pre_rst_ptr", 32'(dut.ptr), 32'd2);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        checkOutput("mid_rst_ready", 32'(req_ready), 32'h0);
        tick();
        checkWord("mid_rst", 1'b0, 2'd0, 4'h0);
        checkOutput("mid_rst_ptr", 32'(dut.ptr), 32'd0);
        applyStimulus(1'b0, 4'b1111, 1'b1);
        checkOutput("post_rst_ready", 32'(req_ready), 32'h1);
        tick();
        checkWord("post_rst", 1'b1, 2'd0, word[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
